// File: rtl/cam_sensor_emu.sv
// cam_sensor_emu: MT9V034-style parallel-video source.
//
// Produces sensor-accurate FRAME_VALID / LINE_VALID / DATA timing on the pixel
// clock, with programmable geometry, blanking and test patterns, plus a frame
// counter. Intended for on-board loopback into the camera capture path and as a
// bench stimulus source.
//
// Ports:
//   CLK          in   pixel clock, all logic on rising edge
//   RST          in   asynchronous active-high reset
//   ENABLE       in   frames are generated while high (checked in idle / frame end)
//   PATTERN_SEL  in   test pattern, latched when FRAME_VALID rises
//   FRAME_VALID  out  sensor FV (registered)
//   LINE_VALID   out  sensor LV (registered)
//   DATA         out  pixel data, zero whenever LINE_VALID is low
//   FRAME_START  out  one-cycle pulse on the FRAME_VALID rising cycle
//   FRAME_COUNT  out  frames completed, wraps 255 -> 0
//
// Build option: define CAM_SENSOR_EMU_LFSR_EN to turn pattern 3 into a
// per-frame-repeating x^10+x^7+1 LFSR sequence instead of the frame stamp.

`timescale 1ns/1ps

module cam_sensor_emu #(
    parameter int unsigned H_ACTIVE = 752,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned H_BLANK  = 94,
    parameter int unsigned V_LEAD   = 1,
    parameter int unsigned V_BLANK  = 45,
    parameter int unsigned CNT_W    = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       ENABLE,
    input  logic [1:0] PATTERN_SEL,
    output logic       FRAME_VALID,
    output logic       LINE_VALID,
    output logic [9:0] DATA,
    output logic       FRAME_START,
    output logic [7:0] FRAME_COUNT
);

    localparam logic [CNT_W-1:0] HA_LAST = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] VA_LAST = CNT_W'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] HB_LAST = CNT_W'(H_BLANK - 1);
    localparam logic [CNT_W-1:0] VL_LAST = CNT_W'(V_LEAD - 1);
    localparam logic [CNT_W-1:0] VB_LAST = CNT_W'(V_BLANK - 1);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    typedef enum logic [2:0] {StIdle, StVblank, StLead, StActive, StHblank} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] row_q;
    logic [CNT_W-1:0] col_q;
    logic [1:0]       pat_q;

`ifdef CAM_SENSOR_EMU_LFSR_EN
    logic [9:0] lfsr_q;
    logic       lfsr_seed;
    logic       pix_load;

    // lfsr_q always holds the value for the next pixel to be loaded into DATA,
    // so it steps once per emitted pixel and the first pixel of a frame is 1.
    always_comb begin
        lfsr_seed = (state_q == StVblank) && (cnt_q == VB_LAST);
        pix_load  = ((state_q == StLead)   && (cnt_q == VL_LAST)) ||
                    ((state_q == StActive) && (col_q != HA_LAST)) ||
                    ((state_q == StHblank) && (cnt_q == HB_LAST));
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lfsr_q <= 10'h001;
        end else if (lfsr_seed) begin
            lfsr_q <= 10'h001;
        end else if (pix_load) begin
            lfsr_q <= {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
        end
    end
`endif

    // Pixel value for (r, c) under the pattern latched for this frame.
    function automatic logic [9:0] pix_value(input logic [CNT_W-1:0] r,
                                             input logic [CNT_W-1:0] c);
        logic [7:0] tag;
        tag = (8'(r) + 8'd1) * 8'd10 + 8'(c) + 8'd1;
        case (pat_q)
            2'd0:    pix_value = {tag, 2'b00};
            2'd1:    pix_value = 10'(c);
            2'd2:    pix_value = 10'h3FF;
`ifdef CAM_SENSOR_EMU_LFSR_EN
            default: pix_value = lfsr_q;
`else
            default: pix_value = {FRAME_COUNT, 2'b00};
`endif
        endcase
    endfunction

    // Outputs are loaded on the edge that enters a state, so each registered
    // output lines up with the cycle the FSM spends in that state.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            row_q       <= '0;
            col_q       <= '0;
            pat_q       <= '0;
            FRAME_VALID <= 1'b0;
            LINE_VALID  <= 1'b0;
            DATA        <= '0;
            FRAME_START <= 1'b0;
            FRAME_COUNT <= '0;
        end else begin
            FRAME_START <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (ENABLE) begin
                        state_q <= StVblank;
                        cnt_q   <= '0;
                    end
                end
                StVblank: begin
                    if (cnt_q == VB_LAST) begin
                        state_q     <= StLead;
                        cnt_q       <= '0;
                        FRAME_VALID <= 1'b1;
                        FRAME_START <= 1'b1;
                        pat_q       <= PATTERN_SEL;
                    end else begin
                        cnt_q <= cnt_q + ONE;
                    end
                end
                StLead: begin
                    if (cnt_q == VL_LAST) begin
                        state_q    <= StActive;
                        cnt_q      <= '0;
                        row_q      <= '0;
                        col_q      <= '0;
                        LINE_VALID <= 1'b1;
                        DATA       <= pix_value('0, '0);
                    end else begin
                        cnt_q <= cnt_q + ONE;
                    end
                end
                StActive: begin
                    if (col_q == HA_LAST) begin
                        LINE_VALID <= 1'b0;
                        DATA       <= '0;
                        cnt_q      <= '0;
                        col_q      <= '0;
                        if (row_q == VA_LAST) begin
                            // End of frame: FV and LV drop together.
                            FRAME_VALID <= 1'b0;
                            FRAME_COUNT <= FRAME_COUNT + 8'd1;
                            row_q       <= '0;
                            state_q     <= ENABLE ? StVblank : StIdle;
                        end else begin
                            state_q <= StHblank;
                        end
                    end else begin
                        col_q <= col_q + ONE;
                        DATA  <= pix_value(row_q, col_q + ONE);
                    end
                end
                StHblank: begin
                    if (cnt_q == HB_LAST) begin
                        state_q    <= StActive;
                        cnt_q      <= '0;
                        row_q      <= row_q + ONE;
                        col_q      <= '0;
                        LINE_VALID <= 1'b1;
                        DATA       <= pix_value(row_q + ONE, '0);
                    end else begin
                        cnt_q <= cnt_q + ONE;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    FRAME_VALID <= 1'b0;
                    LINE_VALID  <= 1'b0;
                    DATA        <= '0;
                end
            endcase
        end
    end

endmodule
